rs_issue_q: RTL and testbench

Unified reservation station feeding the execute stage. Holds dispatched instructions until both source physical registers are ready, wakes operands from the CDB broadcast, selects one ready entry per cycle and drives the registered issue bundle consumed by the functional-unit cluster. It tracks branch masks so that mispredicted-path entries are squashed on recovery, and masks are cleaned on correct prediction.

---
 rtl/rs_issue_q.sv | 156 +++++++++++++++
 tb/tb_rs_issue_q.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_q.sv
// Reservation station: CDB wakeup, lowest-index select, branch-mask squash; issue bundle is registered (2-cycle dispatch-to-issue).
// Backpressure: stall_i suppresses selection; dispatch while full is dropped.
module rs_issue_q #(
  parameter int RS_NUM    = 8,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 4,
  parameter int FU_SEL_W  = 3,
  parameter int ZERO_TAG  = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dp_en_i,
  input  logic [31:0]                dp_IR_i,
  input  logic [FU_SEL_W-1:0]        dp_sel_i,
  input  logic [PRF_IDX_W-1:0]       dp_dest_tag_i,
  input  logic [PRF_IDX_W-1:0]       dp_opa_tag_i,
  input  logic [PRF_IDX_W-1:0]       dp_opb_tag_i,
  input  logic                       dp_opa_rdy_i,
  input  logic                       dp_opb_rdy_i,
  input  logic [ROB_IDX_W:0]         dp_rob_idx_i,
  input  logic [BR_MASK_W-1:0]       dp_br_mask_i,
  input  logic                       cdb_vld_i,
  input  logic [PRF_IDX_W-1:0]       cdb_tag_i,
  input  logic                       stall_i,
  input  logic                       rob_br_recovery_i,
  input  logic                       rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0]       rob_br_tag_fix_i,
  output logic                       rs_full_o,
  output logic [$clog2(RS_NUM):0]    free_cnt_o,
  output logic                       iss_vld_o,
  output logic [31:0]                iss_IR_o,
  output logic [FU_SEL_W-1:0]        iss_sel_o,
  output logic [PRF_IDX_W-1:0]       iss_dest_tag_o,
  output logic [PRF_IDX_W-1:0]       iss_opa_tag_o,
  output logic [PRF_IDX_W-1:0]       iss_opb_tag_o,
  output logic [ROB_IDX_W:0]         iss_rob_idx_o,
  output logic [BR_MASK_W-1:0]       iss_br_mask_o
);

  localparam int IW = $clog2(RS_NUM);
  localparam int CW = $clog2(RS_NUM) + 1;
  localparam logic [PRF_IDX_W-1:0] ZT = PRF_IDX_W'(ZERO_TAG);

  typedef struct packed {
    logic [31:0]          ir;
    logic [FU_SEL_W-1:0]  sel;
    logic [PRF_IDX_W-1:0] dest;
    logic [PRF_IDX_W-1:0] opa_tag;
    logic [PRF_IDX_W-1:0] opb_tag;
    logic [ROB_IDX_W:0]   rob;
    logic [BR_MASK_W-1:0] mask;
  } pl_t;

  typedef struct packed {
    logic vld;
    logic opa_rdy;
    logic opb_rdy;
    pl_t  pl;
  } ent_t;

  ent_t          ent_q [RS_NUM];
  ent_t          ent_d [RS_NUM];
  pl_t           iss_q, iss_d;
  logic          iss_vld_q, iss_vld_d;
  logic [CW-1:0] vld_cnt;
  logic [IW-1:0] dp_idx, sel_idx;
  logic          dp_hit, rdy_hit, dp_fire, sel_fire, cdb_hit;
  logic [BR_MASK_W-1:0] keep_mask;

  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < RS_NUM; i++) vld_cnt = vld_cnt + CW'(ent_q[i].vld);
  end

  assign free_cnt_o = CW'(RS_NUM) - vld_cnt;
  assign rs_full_o  = (vld_cnt == CW'(RS_NUM));

  always_comb begin
    dp_hit  = 1'b0;
    dp_idx  = '0;
    rdy_hit = 1'b0;
    sel_idx = '0;
    // Scan downward so the lowest matching index wins.
    for (int i = RS_NUM - 1; i >= 0; i--) begin
      if (!ent_q[i].vld) begin
        dp_hit = 1'b1;
        dp_idx = IW'(i);
      end
      if (ent_q[i].vld && ent_q[i].opa_rdy && ent_q[i].opb_rdy) begin
        rdy_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign dp_fire   = dp_en_i & dp_hit & ~rob_br_recovery_i;
  assign sel_fire  = rdy_hit & ~stall_i & ~rob_br_recovery_i;
  assign cdb_hit   = cdb_vld_i && (cdb_tag_i != ZT);
  assign keep_mask = rob_br_pred_correct_i ? ~rob_br_tag_fix_i : '1;

  always_comb begin
    for (int i = 0; i < RS_NUM; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_hit && ent_q[i].pl.opa_tag == cdb_tag_i) ent_d[i].opa_rdy = 1'b1;
      if (cdb_hit && ent_q[i].pl.opb_tag == cdb_tag_i) ent_d[i].opb_rdy = 1'b1;
      if (rob_br_recovery_i && |(ent_q[i].pl.mask & rob_br_tag_fix_i)) ent_d[i].vld = 1'b0;
      ent_d[i].pl.mask = ent_q[i].pl.mask & keep_mask;
    end
    if (sel_fire) ent_d[sel_idx].vld = 1'b0;
    if (dp_fire) begin
      ent_d[dp_idx].vld        = 1'b1;
      ent_d[dp_idx].pl.ir      = dp_IR_i;
      ent_d[dp_idx].pl.sel     = dp_sel_i;
      ent_d[dp_idx].pl.dest    = dp_dest_tag_i;
      ent_d[dp_idx].pl.opa_tag = dp_opa_tag_i;
      ent_d[dp_idx].pl.opb_tag = dp_opb_tag_i;
      ent_d[dp_idx].pl.rob     = dp_rob_idx_i;
      ent_d[dp_idx].pl.mask    = dp_br_mask_i & keep_mask;
      ent_d[dp_idx].opa_rdy    = dp_opa_rdy_i | (dp_opa_tag_i == ZT) |
                                 (cdb_hit && dp_opa_tag_i == cdb_tag_i);
      ent_d[dp_idx].opb_rdy    = dp_opb_rdy_i | (dp_opb_tag_i == ZT) |
                                 (cdb_hit && dp_opb_tag_i == cdb_tag_i);
    end
  end

  // Recovery blocks selection, so a squashed issue slot simply drops valid.
  always_comb begin
    iss_vld_d = sel_fire;
    iss_d     = iss_q;
    if (sel_fire) iss_d = ent_q[sel_idx].pl;
    iss_d.mask = iss_d.mask & keep_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_NUM; i++) ent_q[i] <= '0;
      iss_q     <= '0;
      iss_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_NUM; i++) ent_q[i] <= ent_d[i];
      iss_q     <= iss_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  assign iss_vld_o      = iss_vld_q;
  assign iss_IR_o       = iss_q.ir;
  assign iss_sel_o      = iss_q.sel;
  assign iss_dest_tag_o = iss_q.dest;
  assign iss_opa_tag_o  = iss_q.opa_tag;
  assign iss_opb_tag_o  = iss_q.opb_tag;
  assign iss_rob_idx_o  = iss_q.rob;
  assign iss_br_mask_o  = iss_q.mask;

endmodule

// File: tb/tb_rs_issue_q.sv
// Scoreboard bench for rs_issue_q: expected bundles are queued at dispatch and popped at issue.
module tb_rs_issue_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        dp_en_i;
  logic [31:0] dp_IR_i;
  logic [2:0]  dp_sel_i;
  logic [5:0]  dp_dest_tag_i, dp_opa_tag_i, dp_opb_tag_i;
  logic        dp_opa_rdy_i, dp_opb_rdy_i;
  logic [5:0]  dp_rob_idx_i;
  logic [3:0]  dp_br_mask_i;
  logic        cdb_vld_i;
  logic [5:0]  cdb_tag_i;
  logic        stall_i, rob_br_recovery_i, rob_br_pred_correct_i;
  logic [3:0]  rob_br_tag_fix_i;
  logic        rs_full_o;
  logic [3:0]  free_cnt_o;
  logic        iss_vld_o;
  logic [31:0] iss_IR_o;
  logic [2:0]  iss_sel_o;
  logic [5:0]  iss_dest_tag_o, iss_opa_tag_o, iss_opb_tag_o, iss_rob_idx_o;
  logic [3:0]  iss_br_mask_o;

  int total = 0;
  int bad   = 0;
  logic [62:0] exp_q[$];
  logic [62:0] exp_b;
  logic [62:0] iss_bus;

  assign iss_bus = {iss_IR_o, iss_sel_o, iss_dest_tag_o, iss_opa_tag_o,
                    iss_opb_tag_o, iss_rob_idx_o, iss_br_mask_o};

  always #5 clk = ~clk;

  rs_issue_q dut (
    .clk(clk), .rst(rst),
    .dp_en_i(dp_en_i), .dp_IR_i(dp_IR_i), .dp_sel_i(dp_sel_i),
    .dp_dest_tag_i(dp_dest_tag_i), .dp_opa_tag_i(dp_opa_tag_i), .dp_opb_tag_i(dp_opb_tag_i),
    .dp_opa_rdy_i(dp_opa_rdy_i), .dp_opb_rdy_i(dp_opb_rdy_i),
    .dp_rob_idx_i(dp_rob_idx_i), .dp_br_mask_i(dp_br_mask_i),
    .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .stall_i(stall_i),
    .rob_br_recovery_i(rob_br_recovery_i), .rob_br_pred_correct_i(rob_br_pred_correct_i),
    .rob_br_tag_fix_i(rob_br_tag_fix_i),
    .rs_full_o(rs_full_o), .free_cnt_o(free_cnt_o), .iss_vld_o(iss_vld_o),
    .iss_IR_o(iss_IR_o), .iss_sel_o(iss_sel_o), .iss_dest_tag_o(iss_dest_tag_o),
    .iss_opa_tag_o(iss_opa_tag_o), .iss_opb_tag_o(iss_opb_tag_o),
    .iss_rob_idx_o(iss_rob_idx_o), .iss_br_mask_o(iss_br_mask_o)
  );

  // sel/dest/rob are derived from the IR so the expected bundle follows from the IR alone.
  function automatic logic [62:0] mk(input logic [31:0] ir, input logic [5:0] a,
                                     input logic [5:0] b, input logic [3:0] mask);
    return {ir, ir[2:0], ir[13:8], a, b, ir[21:16], mask};
  endfunction

  // Drives one dispatch across a single clock edge; returns at the following negedge.
  task automatic dispatch(input logic [31:0] ir, input logic [5:0] a, input logic ar,
                          input logic [5:0] b, input logic br, input logic [3:0] mask);
    dp_en_i = 1'b1; dp_IR_i = ir; dp_sel_i = ir[2:0]; dp_dest_tag_i = ir[13:8];
    dp_rob_idx_i = ir[21:16]; dp_opa_tag_i = a; dp_opa_rdy_i = ar;
    dp_opb_tag_i = b; dp_opb_rdy_i = br; dp_br_mask_i = mask;
    @(negedge clk);
    dp_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dp_en_i = 0; dp_IR_i = 0; dp_sel_i = 0; dp_dest_tag_i = 0;
    dp_opa_tag_i = 0; dp_opb_tag_i = 0; dp_opa_rdy_i = 0; dp_opb_rdy_i = 0;
    dp_rob_idx_i = 0; dp_br_mask_i = 0; cdb_vld_i = 0; cdb_tag_i = 0; stall_i = 0;
    rob_br_recovery_i = 0; rob_br_pred_correct_i = 0; rob_br_tag_fix_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL reset_iss_vld: got %b want 0", iss_vld_o); end
    total++; if (iss_bus !== 63'd0) begin bad++; $display("FAIL reset_bundle: got %h want 0", iss_bus); end
    total++; if (rs_full_o !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", rs_full_o); end
    total++; if (free_cnt_o !== 4'd8) begin bad++; $display("FAIL reset_free_cnt: got %0d want 8", free_cnt_o); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] ir;
    stall_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ir = 32'h1000_0000 | ({$urandom} & 32'h00FF_FF00) | 32'(k);
      dispatch(ir, 6'(k), 1'b1, 6'(k + 8), 1'b1, 4'd0);
      exp_q.push_back(mk(ir, 6'(k), 6'(k + 8), 4'd0));
      total++; if (free_cnt_o !== 4'(7 - k)) begin bad++; $display("FAIL fill_free_cnt[%0d]: got %0d want %0d", k, free_cnt_o, 7 - k); end
    end
    total++; if (rs_full_o !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", rs_full_o); end
    dispatch(32'hDEAD_BEEF, 6'd1, 1'b1, 6'd2, 1'b1, 4'd0);
    total++; if (free_cnt_o !== 4'd0) begin bad++; $display("FAIL drop_when_full: got %0d want 0", free_cnt_o); end
    stall_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_b = exp_q.pop_front();
      total++; if (iss_vld_o !== 1'b1) begin bad++; $display("FAIL drain_vld[%0d]: got %b want 1", k, iss_vld_o); end
      total++; if (iss_bus !== exp_b) begin bad++; $display("FAIL drain_bundle[%0d]: got %h want %h", k, iss_bus, exp_b); end
    end
    @(negedge clk);
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL drain_extra_issue: got %b want 0", iss_vld_o); end
    total++; if (free_cnt_o !== 4'd8) begin bad++; $display("FAIL drain_free_cnt: got %0d want 8", free_cnt_o); end
  endtask

  task automatic test_cdb_wakeup();
    dispatch(32'h2001_0A05, 6'd12, 1'b0, 6'd3, 1'b1, 4'd0);
    exp_q.push_back(mk(32'h2001_0A05, 6'd12, 6'd3, 4'd0));
    repeat (2) begin
      @(negedge clk);
      total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL wake_early_issue: got %b want 0", iss_vld_o); end
    end
    cdb_vld_i = 1'b1; cdb_tag_i = 6'd12;
    @(negedge clk);
    cdb_vld_i = 1'b0;
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL wake_n1_vld: got %b want 0", iss_vld_o); end
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1) begin bad++; $display("FAIL wake_n2_vld: got %b want 1", iss_vld_o); end
    total++; if (iss_bus !== exp_b) begin bad++; $display("FAIL wake_bundle: got %h want %h", iss_bus, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_bypass_and_zero();
    cdb_vld_i = 1'b1; cdb_tag_i = 6'd7;
    dispatch(32'h3002_1B06, 6'd4, 1'b1, 6'd7, 1'b0, 4'd0);
    cdb_vld_i = 1'b0;
    exp_q.push_back(mk(32'h3002_1B06, 6'd4, 6'd7, 4'd0));
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL bypass_issue: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    dispatch(32'h3103_2C01, 6'd31, 1'b0, 6'd9, 1'b1, 4'd0);
    exp_q.push_back(mk(32'h3103_2C01, 6'd31, 6'd9, 4'd0));
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL zero_tag_issue: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_recovery();
    stall_i = 1'b1;
    dispatch(32'h4004_0102, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0001);
    dispatch(32'h4105_0203, 6'd3, 1'b1, 6'd4, 1'b1, 4'b0010);
    exp_q.push_back(mk(32'h4105_0203, 6'd3, 6'd4, 4'b0010));
    total++; if (free_cnt_o !== 4'd6) begin bad++; $display("FAIL rec_pre_free_cnt: got %0d want 6", free_cnt_o); end
    rob_br_recovery_i = 1'b1; rob_br_tag_fix_i = 4'b0001;
    dispatch(32'h4206_0304, 6'd5, 1'b1, 6'd6, 1'b1, 4'b0000);
    rob_br_recovery_i = 1'b0; rob_br_tag_fix_i = 4'd0; stall_i = 1'b0;
    total++; if (free_cnt_o !== 4'd7) begin bad++; $display("FAIL rec_free_cnt: got %0d want 7", free_cnt_o); end
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL rec_survivor: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    @(negedge clk);
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL rec_squashed_issue: got %b want 0", iss_vld_o); end
    total++; if (free_cnt_o !== 4'd8) begin bad++; $display("FAIL rec_end_free_cnt: got %0d want 8", free_cnt_o); end
  endtask

  task automatic test_pred_correct_b2b();
    dispatch(32'h5007_0405, 6'd20, 1'b0, 6'd5, 1'b1, 4'b0011);
    exp_q.push_back(mk(32'h5006_0506, 6'd8, 6'd9, 4'b0100));
    exp_q.push_back(mk(32'h5007_0405, 6'd20, 6'd5, 4'b0001));
    rob_br_pred_correct_i = 1'b1; rob_br_tag_fix_i = 4'b0010;
    dispatch(32'h5006_0506, 6'd8, 1'b1, 6'd9, 1'b1, 4'b0110);
    rob_br_pred_correct_i = 1'b0; rob_br_tag_fix_i = 4'd0;
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL pc_early_issue: got %b want 0", iss_vld_o); end
    cdb_vld_i = 1'b1; cdb_tag_i = 6'd20;
    @(negedge clk);
    cdb_vld_i = 1'b0;
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL pc_same_cycle_dp: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL pc_waiting_entry: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    dispatch(32'h6008_0607, 6'd10, 1'b1, 6'd11, 1'b1, 4'b1000);
    exp_q.push_back(mk(32'h6008_0607, 6'd10, 6'd11, 4'b1000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL stall_vld[%0d]: got %b want 0", k, iss_vld_o); end
    end
    stall_i = 1'b0;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    total++; if (iss_vld_o !== 1'b1 || iss_bus !== exp_b) begin bad++; $display("FAIL stall_release: got vld=%b %h want vld=1 %h", iss_vld_o, iss_bus, exp_b); end
    @(negedge clk);
    total++; if (iss_vld_o !== 1'b0) begin bad++; $display("FAIL stall_pulse: got %b want 0", iss_vld_o); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_cdb_wakeup();
    test_bypass_and_zero();
    test_recovery();
    test_pred_correct_b2b();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
